// File: rtl/line_xfer_pkg.sv
// Shared types and system-bus constants for the cache-line transfer engine.
package line_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int REQTAG_W = 13;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    // Tag layout: direction in bit 12, target space in bits 11:8.
    function automatic logic [REQTAG_W-1:0] make_reqtag(input logic write);
        logic [REQTAG_W-1:0] w_tag;
        w_tag        = '0;
        w_tag[12]    = write ? SYSBUS_WRITE : SYSBUS_READ;
        w_tag[11:8]  = SYSBUS_MEMORY;
        return w_tag;
    endfunction

endpackage

// File: rtl/line_xfer_unit_beat_buffer.sv
// One-line beat buffer: full-line load, indexed beat write (fill) and
// indexed beat read (write-back), plus a look-ahead view of the next line.
module line_beat_buffer #(
    parameter  int BUS_DATA_WIDTH = 64,
    parameter  int LINE_BEATS     = 8,
    localparam int IDX_W          = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1,
    localparam int LINE_W         = BUS_DATA_WIDTH * LINE_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic [LINE_W-1:0]         i_load_line,
    input  logic                      i_wr_en,
    input  logic [IDX_W-1:0]          i_wr_idx,
    input  logic [BUS_DATA_WIDTH-1:0] i_wr_data,
    input  logic [IDX_W-1:0]          i_rd_idx,
    output logic [BUS_DATA_WIDTH-1:0] o_rd_data,
    output logic [LINE_W-1:0]         o_line_next
);

    logic [BUS_DATA_WIDTH-1:0] r_beats [LINE_BEATS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < LINE_BEATS; k++) begin
                r_beats[k] <= '0;
            end
        end else if (i_load) begin
            for (int k = 0; k < LINE_BEATS; k++) begin
                r_beats[k] <= i_load_line[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            end
        end else if (i_wr_en) begin
            r_beats[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_beats[i_rd_idx];

    // Line as it will look after this cycle's beat write, so the final beat
    // can be published without an extra cycle.
    always_comb begin
        o_line_next = '0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                o_line_next[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = i_wr_data;
            end else begin
                o_line_next[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = r_beats[k];
            end
        end
    end

endmodule

// File: rtl/line_xfer_unit.sv
// Cache-line transfer engine: arbitrates for the system bus, then issues an
// address beat followed by a line of write data, or collects a line of fill data.
module line_xfer_unit
    import line_xfer_pkg::*;
#(
    parameter  int BUS_DATA_WIDTH = 64,
    parameter  int BUS_TAG_WIDTH  = 13,
    parameter  int ADDR_WIDTH     = 64,
    parameter  int LINE_BEATS     = 8,
    localparam int LINE_W         = BUS_DATA_WIDTH * LINE_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [LINE_W-1:0]         req_wdata,
    output logic                      resp_valid,
    output logic                      resp_write,
    output logic [LINE_W-1:0]         resp_rdata,
    output logic                      abtr_reqcyc,
    input  logic                      abtr_grant,
    output logic                      bus_busy,
    output logic                      main_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
    input  logic                      main_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
    output logic                      main_bus_respack,
    output state_t                    o_dbg_state
);

    localparam int OFF   = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 8);
    localparam int CNT_W = $clog2(LINE_BEATS) + 1;
    localparam int IDX_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

    state_t                    r_state;
    state_t                    w_next_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_write;
    logic [LINE_W-1:0]         r_resp_rdata;

    logic                      w_accept;
    logic                      w_beat_last;
    logic                      w_fill_store;
    logic [BUS_DATA_WIDTH-1:0] w_wr_beat;
    logic [LINE_W-1:0]         w_line_next;

    // Request handshake: a transfer is taken on any edge where req_valid and
    // req_ready are both high; req_ready is high only while idle, so requests
    // presented during a transfer are simply not taken.
    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_beat_last  = (r_cnt == LAST_BEAT);
    assign w_fill_store = (r_state == RDATA) && main_bus_respcyc;

    line_beat_buffer #(
        .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
        .LINE_BEATS     (LINE_BEATS)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_load_line (req_wdata),
        .i_wr_en     (w_fill_store),
        .i_wr_idx    (r_cnt[IDX_W-1:0]),
        .i_wr_data   (main_bus_resp),
        .i_rd_idx    (r_cnt[IDX_W-1:0]),
        .o_rd_data   (w_wr_beat),
        .o_line_next (w_line_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ARB;
            ARB:     if (abtr_grant) w_next_state = ADDR;
            ADDR:    w_next_state = r_write ? WDATA : RDATA;
            WDATA:   if (w_beat_last) w_next_state = DONE;
            RDATA:   if (w_fill_store && w_beat_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr & ADDR_MASK;
                r_write <= req_write;
                r_cnt   <= '0;
            end
            case (r_state)
                ADDR:    r_cnt <= '0;
                WDATA:   r_cnt <= r_cnt + CNT_W'(1);
                RDATA:   if (w_fill_store) r_cnt <= r_cnt + CNT_W'(1);
                default: ;
            endcase
            // The visible fill line only changes once the whole line is in.
            if (w_fill_store && w_beat_last) begin
                r_resp_rdata <= w_line_next;
            end
        end
    end

    always_comb begin
        req_ready        = 1'b0;
        abtr_reqcyc      = 1'b0;
        bus_busy         = 1'b0;
        main_bus_reqcyc  = 1'b0;
        main_bus_req     = '0;
        main_bus_reqtag  = '0;
        main_bus_respack = 1'b0;
        resp_valid       = 1'b0;
        resp_write       = 1'b0;
        case (r_state)
            IDLE: req_ready = 1'b1;
            ARB:  abtr_reqcyc = 1'b1;
            ADDR: begin
                main_bus_reqcyc = 1'b1;
                main_bus_req    = BUS_DATA_WIDTH'(r_addr);
                main_bus_reqtag = BUS_TAG_WIDTH'(make_reqtag(r_write));
                bus_busy        = 1'b1;
            end
            WDATA: begin
                main_bus_reqcyc = 1'b1;
                main_bus_req    = w_wr_beat;
                main_bus_reqtag = BUS_TAG_WIDTH'(make_reqtag(r_write));
                bus_busy        = 1'b1;
            end
            RDATA: begin
                bus_busy         = 1'b1;
                main_bus_respack = main_bus_respcyc;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_write = r_write;
            end
            default: ;
        endcase
    end

    assign resp_rdata  = r_resp_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_line_xfer_unit.sv
// Bench for line_xfer_unit: default build plus a 4-beat, 32-bit build.
module tb_line_xfer_unit;
    import line_xfer_pkg::*;

    localparam int DW   = 64;
    localparam int LB   = 8;
    localparam int LW   = DW * LB;
    localparam int DW_B = 32;
    localparam int LB_B = 4;
    localparam int LW_B = DW_B * LB_B;
    localparam logic [12:0] TAG_RD = 13'h1100;
    localparam logic [12:0] TAG_WR = 13'h0100;

    logic clk;
    logic reset;

    logic            req_valid, req_ready, req_write;
    logic [63:0]     req_addr;
    logic [LW-1:0]   req_wdata;
    logic            resp_valid, resp_write;
    logic [LW-1:0]   resp_rdata;
    logic            abtr_reqcyc, abtr_grant, bus_busy;
    logic            main_bus_reqcyc;
    logic [DW-1:0]   main_bus_req;
    logic [12:0]     main_bus_reqtag;
    logic            main_bus_respcyc;
    logic [DW-1:0]   main_bus_resp;
    logic            main_bus_respack;
    state_t          dbg_state;

    logic            req_valid_b, req_ready_b, req_write_b;
    logic [31:0]     req_addr_b;
    logic [LW_B-1:0] req_wdata_b;
    logic            resp_valid_b, resp_write_b;
    logic [LW_B-1:0] resp_rdata_b;
    logic            abtr_reqcyc_b, abtr_grant_b, bus_busy_b;
    logic            main_bus_reqcyc_b;
    logic [DW_B-1:0] main_bus_req_b;
    logic [12:0]     main_bus_reqtag_b;
    logic            main_bus_respcyc_b;
    logic [DW_B-1:0] main_bus_resp_b;
    logic            main_bus_respack_b;
    state_t          dbg_state_b;

    int total;
    int bad;
    logic [LW:0]     exp_q[$];
    logic [DW-1:0]   beat_q[$];
    logic [LW_B-1:0] exp_q_b[$];
    logic [LW-1:0]   model_rdata;

    line_xfer_unit u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_write(resp_write), .resp_rdata(resp_rdata),
        .abtr_reqcyc(abtr_reqcyc), .abtr_grant(abtr_grant), .bus_busy(bus_busy),
        .main_bus_reqcyc(main_bus_reqcyc), .main_bus_req(main_bus_req),
        .main_bus_reqtag(main_bus_reqtag), .main_bus_respcyc(main_bus_respcyc),
        .main_bus_resp(main_bus_resp), .main_bus_respack(main_bus_respack),
        .o_dbg_state(dbg_state)
    );

    line_xfer_unit #(
        .BUS_DATA_WIDTH(DW_B), .BUS_TAG_WIDTH(13), .ADDR_WIDTH(32), .LINE_BEATS(LB_B)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_write(resp_write_b), .resp_rdata(resp_rdata_b),
        .abtr_reqcyc(abtr_reqcyc_b), .abtr_grant(abtr_grant_b), .bus_busy(bus_busy_b),
        .main_bus_reqcyc(main_bus_reqcyc_b), .main_bus_req(main_bus_req_b),
        .main_bus_reqtag(main_bus_reqtag_b), .main_bus_respcyc(main_bus_respcyc_b),
        .main_bus_resp(main_bus_resp_b), .main_bus_respack(main_bus_respack_b),
        .o_dbg_state(dbg_state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        abtr_grant = 1'b0; main_bus_respcyc = 1'b0; main_bus_resp = '0;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
        abtr_grant_b = 1'b0; main_bus_respcyc_b = 1'b0; main_bus_resp_b = '0;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Full transfer on the default build. Starts and ends just after a posedge.
    // gd: grant delay; gap_len idle response cycles after beat gap_at; noise
    // drives requests/grants/responses where they must be ignored.
    task automatic run_xfer(input logic wr, input logic [63:0] addr,
                            input logic [LW-1:0] line, input int gd,
                            input int gap_at, input int gap_len, input bit noise);
        logic [63:0] exp_addr;
        logic [LW:0] e;
        int exp_done, beat_idx, gap_left, pulses;
        bit drove_beat;
        exp_addr = addr & ~64'h3F;
        exp_done = wr ? (3 + gd + LB) : (3 + gd + LB + gap_len);
        if (wr) begin
            exp_q.push_back({1'b1, model_rdata});
            for (int k = 0; k < LB; k++) beat_q.push_back(line[k*DW +: DW]);
        end else begin
            exp_q.push_back({1'b0, line});
            model_rdata = line;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wr ? line : rand_line();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = noise; req_write = ~wr; req_addr = {$urandom, $urandom};
        beat_idx = 0; gap_left = 0; pulses = 0;
        for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
            drove_beat = 1'b0;
            req_valid  = noise && (cyc < exp_done);
            abtr_grant = (cyc == 1 + gd) || (noise && cyc > 2 + gd);
            main_bus_resp = {$urandom, $urandom};
            if (!wr && cyc >= 3 + gd && beat_idx < LB) begin
                if (gap_left > 0) begin
                    main_bus_respcyc = 1'b0;
                    gap_left--;
                end else begin
                    main_bus_respcyc = 1'b1;
                    main_bus_resp = line[beat_idx*DW +: DW];
                    drove_beat = 1'b1;
                    beat_idx++;
                    if (gap_len > 0 && beat_idx == gap_at + 1) gap_left = gap_len;
                end
            end else begin
                main_bus_respcyc = noise && (cyc < 3 + gd);
            end
            @(negedge clk);
            total++;
            if (abtr_reqcyc !== (cyc <= 1 + gd)) begin
                bad++; $display("FAIL abtr_reqcyc c%0d: got %b want %b", cyc, abtr_reqcyc, cyc <= 1 + gd);
            end
            total++;
            if (main_bus_reqcyc !== ((cyc == 2 + gd) || (wr && cyc >= 3 + gd && cyc <= 2 + gd + LB))) begin
                bad++; $display("FAIL reqcyc c%0d: got %b", cyc, main_bus_reqcyc);
            end
            if (cyc == 2 + gd) begin
                total++;
                if (main_bus_req !== exp_addr) begin
                    bad++; $display("FAIL addr_beat: got %0h want %0h", main_bus_req, exp_addr);
                end
            end
            if (cyc >= 2 + gd && cyc <= 2 + gd + (wr ? LB : 0)) begin
                total++;
                if (main_bus_reqtag !== (wr ? TAG_WR : TAG_RD)) begin
                    bad++; $display("FAIL reqtag c%0d: got %0h want %0h", cyc, main_bus_reqtag, wr ? TAG_WR : TAG_RD);
                end
            end
            if (wr && cyc >= 3 + gd && cyc <= 2 + gd + LB) begin
                total++;
                if (beat_q.size() == 0) begin
                    bad++; $display("FAIL wbeat c%0d: got %0h want none", cyc, main_bus_req);
                end else if (main_bus_req !== beat_q[0]) begin
                    bad++; $display("FAIL wbeat c%0d: got %0h want %0h", cyc, main_bus_req, beat_q[0]);
                    void'(beat_q.pop_front());
                end else begin
                    void'(beat_q.pop_front());
                end
            end
            total++;
            if (main_bus_respack !== drove_beat) begin
                bad++; $display("FAIL respack c%0d: got %b want %b", cyc, main_bus_respack, drove_beat);
            end
            total++;
            if (bus_busy !== (cyc >= 2 + gd && cyc < exp_done)) begin
                bad++; $display("FAIL bus_busy c%0d: got %b", cyc, bus_busy);
            end
            total++;
            if (req_ready !== (cyc > exp_done)) begin
                bad++; $display("FAIL req_ready c%0d: got %b", cyc, req_ready);
            end
            total++;
            if (resp_valid !== (cyc == exp_done)) begin
                bad++; $display("FAIL resp_valid c%0d: got %b want %b", cyc, resp_valid, cyc == exp_done);
            end
            if (resp_valid === 1'b1) begin
                pulses++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL resp_unexpected: got %0h want none", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({resp_write, resp_rdata} !== e) begin
                        bad++; $display("FAIL resp_line: got %b/%0h want %b/%0h", resp_write, resp_rdata, e[LW], e[LW-1:0]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL resp_count: got %0d want 1", pulses); end
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({req_ready, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, resp_valid, resp_write} !== 7'b1000000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 1000000", {req_ready, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, resp_valid, resp_write});
        end
        total++;
        if ({main_bus_req, main_bus_reqtag, resp_rdata} !== '0) begin
            bad++; $display("FAIL reset_data: got %0h/%0h/%0h want 0", main_bus_req, main_bus_reqtag, resp_rdata);
        end
        total++;
        if ({req_ready_b, bus_busy_b, resp_valid_b, resp_rdata_b} !== {1'b1, 1'b0, 1'b0, {LW_B{1'b0}}}) begin
            bad++; $display("FAIL reset_b: got %b%b%b/%0h want 100/0", req_ready_b, bus_busy_b, resp_valid_b, resp_rdata_b);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_rdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_basic();
        logic [LW-1:0] line;
        for (int k = 0; k < LB; k++) line[k*DW +: DW] = 64'((k + 1) * 17);
        run_xfer(1'b0, 64'h1234_5678, line, 0, 0, 0, 1'b0);
        total++;
        if (resp_rdata[63:0] !== 64'h11 || resp_rdata[511:448] !== 64'h88) begin
            bad++; $display("FAIL fill_edges: got %0h/%0h want 11/88", resp_rdata[63:0], resp_rdata[511:448]);
        end
    endtask

    task automatic test_fill_unaligned();
        run_xfer(1'b0, 64'h1000_003F, rand_line(), 0, 0, 0, 1'b0);
    endtask

    task automatic test_write_back();
        logic [LW-1:0] line;
        for (int k = 0; k < LB; k++) line[k*DW +: DW] = 64'(8'hA0 + k);
        run_xfer(1'b1, 64'h0000_0000_8000_0040, line, 0, 0, 0, 1'b0);
    endtask

    task automatic test_fill_gap();
        run_xfer(1'b0, 64'h0000_00AB_CDEF_0000, rand_line(), 5, 3, 2, 1'b1);
    endtask

    task automatic test_reset_midfill();
        logic [LW-1:0] line;
        line = rand_line();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h2000_0040;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            abtr_grant = (cyc == 1);
            main_bus_respcyc = (cyc >= 3);
            if (cyc >= 3) main_bus_resp = line[(cyc-3)*DW +: DW];
            if (cyc == 7) reset = 1'b0;
            @(negedge clk);
            if (cyc == 7) begin
                total++;
                if (bus_busy !== 1'b1) begin bad++; $display("FAIL midfill_busy: got %b want 1", bus_busy); end
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; abtr_grant = 1'b1; main_bus_respcyc = 1'b1; main_bus_resp = {$urandom, $urandom};
        @(negedge clk);
        total++;
        if ({req_ready, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, resp_valid} !== 6'b100000) begin
            bad++; $display("FAIL abort_ctrl: got %b want 100000", {req_ready, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, resp_valid});
        end
        total++;
        if ({main_bus_req, main_bus_reqtag, resp_rdata} !== '0) begin
            bad++; $display("FAIL abort_data: got %0h/%0h/%0h want 0", main_bus_req, main_bus_reqtag, resp_rdata);
        end
        model_rdata = '0;
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++; $display("FAIL abort_quiet: got %b%b want 01", resp_valid, req_ready);
            end
            @(posedge clk); #1;
        end
        run_xfer(1'b0, 64'h3000_0080, rand_line(), 1, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b1, {$urandom, $urandom}, rand_line(), $urandom_range(0, 3), 0, 0, 1'b0);
        run_xfer(1'b0, {$urandom, $urandom}, rand_line(), $urandom_range(0, 3), 2, 1, 1'b0);
        run_xfer(1'b1, {$urandom, $urandom}, rand_line(), 0, 0, 0, 1'b1);
    endtask

    task automatic test_small_fill();
        logic [LW_B-1:0] line;
        int pulses;
        for (int k = 0; k < LB_B; k++) line[k*DW_B +: DW_B] = $urandom;
        exp_q_b.push_back(line);
        pulses = 0;
        req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 32'h1234_567F;
        @(negedge clk);
        total++;
        if (req_ready_b !== 1'b1) begin bad++; $display("FAIL b_ready: got %b want 1", req_ready_b); end
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            abtr_grant_b = (cyc == 1);
            main_bus_respcyc_b = (cyc >= 3 && cyc <= 6);
            main_bus_resp_b = (cyc >= 3 && cyc <= 6) ? line[(cyc-3)*DW_B +: DW_B] : 32'(0);
            @(negedge clk);
            total++;
            if (main_bus_reqcyc_b !== (cyc == 2)) begin
                bad++; $display("FAIL b_reqcyc c%0d: got %b", cyc, main_bus_reqcyc_b);
            end
            if (cyc == 2) begin
                total++;
                if (main_bus_req_b !== 32'h1234_5670 || main_bus_reqtag_b !== TAG_RD) begin
                    bad++; $display("FAIL b_addr: got %0h/%0h want 12345670/%0h", main_bus_req_b, main_bus_reqtag_b, TAG_RD);
                end
            end
            total++;
            if (main_bus_respack_b !== (cyc >= 3 && cyc <= 6)) begin
                bad++; $display("FAIL b_respack c%0d: got %b", cyc, main_bus_respack_b);
            end
            total++;
            if (resp_valid_b !== (cyc == 7)) begin
                bad++; $display("FAIL b_resp_valid c%0d: got %b want %b", cyc, resp_valid_b, cyc == 7);
            end
            if (resp_valid_b === 1'b1) begin
                pulses++;
                total++;
                if (exp_q_b.size() == 0) begin
                    bad++; $display("FAIL b_line: got %0h want none", resp_rdata_b);
                end else if (resp_rdata_b !== exp_q_b[0] || resp_write_b !== 1'b0) begin
                    bad++; $display("FAIL b_line: got %b/%0h want 0/%0h", resp_write_b, resp_rdata_b, exp_q_b[0]);
                    void'(exp_q_b.pop_front());
                end else begin
                    void'(exp_q_b.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL b_resp_count: got %0d want 1", pulses); end
        drive_idle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_rdata = '0;
        reset = 1'b0;
        test_reset();
        test_fill_basic();
        test_fill_unaligned();
        test_write_back();
        test_fill_gap();
        test_reset_midfill();
        test_back_to_back();
        test_small_fill();
        total++;
        if (exp_q.size() != 0 || exp_q_b.size() != 0 || beat_q.size() != 0) begin
            bad++; $display("FAIL queues_drained: got %0d/%0d/%0d want 0/0/0", exp_q.size(), exp_q_b.size(), beat_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
